// File: rtl/cp0_int_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, field positions, write mask and
// the interrupt scheduler state type.
package cp0_int_ctrl_pkg;

   localparam logic [4:0]  REG_SR    = 5'd12;
   localparam logic [4:0]  REG_CAUSE = 5'd13;
   localparam logic [4:0]  REG_EPC   = 5'd14;
   localparam logic [4:0]  REG_PRID  = 5'd15;

   localparam int unsigned IM_LO     = 10;
   localparam int unsigned IP_LO     = 10;
   localparam int unsigned EXL_BIT   = 1;
   localparam int unsigned IE_BIT    = 0;
   localparam int unsigned BD_BIT    = 31;
   localparam int unsigned EXC_LO    = 2;

   localparam logic [31:0] SR_WMASK  = 32'h0000_FC03;
   localparam logic [4:0]  EXC_INT   = 5'd0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } cp0_state_e;

endpackage

// File: rtl/cp0_int_ctrl.sv
// CP0 register file (SR, Cause, EPC, PRId) with mfc0/mtc0/eret handling and
// the hardware interrupt scheduler that never takes an interrupt on a bubble.
module cp0_int_ctrl
   import cp0_int_ctrl_pkg::*;
#(
   parameter int unsigned NUM_HWINT  = 6,
   parameter logic [31:0] PRID       = 32'h4A4C_0001,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_HWINT-1:0] HWInt,
   input  logic [31:0]          PCM,
   input  logic                 ValidM,
   input  logic                 BDM,
   input  logic                 WeM,
   input  logic [4:0]           AddrM,
   input  logic [31:0]          DInM,
   input  logic                 EretM,
   output logic [31:0]          DOutM,
   output logic                 IntReq,
   output logic [31:0]          HandlerPC,
   output logic [31:0]          EPCOut
);

   logic [NUM_HWINT-1:0] im;
   logic [NUM_HWINT-1:0] ip;
   logic                 exl;
   logic                 ie;
   logic                 bd;
   logic [4:0]           exc_code;
   logic [31:0]          epc;
   cp0_state_e           state;

   logic                 pend;
   logic                 wr_sr;
   logic                 wr_epc;
   logic                 eret_ok;
   logic [31:0]          sr_word;
   logic [31:0]          cause_word;
   logic [31:0]          epc_wdata;

   assign pend      = (|(ip & im)) & ie & ~exl;
   // The interrupt is taken in the same cycle the M stage holds a real
   // instruction, from either state; the state only tracks the waiting period.
   assign IntReq    = pend & ValidM & ~reset;
   assign wr_sr     = WeM & (AddrM == REG_SR)  & ~IntReq;
   assign wr_epc    = WeM & (AddrM == REG_EPC) & ~IntReq;
   assign eret_ok   = EretM & ~IntReq;
   assign epc_wdata = {DInM[31:2], 2'b00};
   assign HandlerPC = HANDLER_PC;
   assign EPCOut    = wr_epc ? epc_wdata : epc;

   always_comb begin
      sr_word                          = '0;
      sr_word[IM_LO +: NUM_HWINT]      = im;
      sr_word[EXL_BIT]                 = exl;
      sr_word[IE_BIT]                  = ie;
      sr_word                          = sr_word & SR_WMASK;
      cause_word                       = '0;
      cause_word[BD_BIT]               = bd;
      cause_word[IP_LO +: NUM_HWINT]   = ip;
      cause_word[EXC_LO +: 5]          = exc_code;
   end

   always_comb begin
      DOutM = '0;
      case (AddrM)
         REG_SR:    DOutM = sr_word;
         REG_CAUSE: DOutM = cause_word;
         REG_EPC:   DOutM = epc;
         REG_PRID:  DOutM = PRID;
         default:   DOutM = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= '0;
         ip       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         exc_code <= '0;
         epc      <= '0;
         state    <= ST_IDLE;
      end else begin
         ip <= HWInt;

         case (state)
            ST_IDLE: if (pend && !ValidM) state <= ST_WAIT;
            ST_WAIT: if (!pend || ValidM) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         if (IntReq) begin
            epc      <= BDM ? (PCM - 32'd4) : PCM;
            bd       <= BDM;
            exc_code <= EXC_INT;
            exl      <= 1'b1;
         end else begin
            if (wr_sr) begin
               im  <= DInM[IM_LO +: NUM_HWINT];
               exl <= DInM[EXL_BIT];
               ie  <= DInM[IE_BIT];
            end
            if (wr_epc) epc <= epc_wdata;
            // Placed after the SR write so eret owns EXL if both occur.
            if (eret_ok) exl <= 1'b0;
         end
      end
   end

endmodule
